// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: inverse S-box, GF(2^8)
// helpers, round-count constants and the FSM state type.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_e;

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multipliers used here never exceed 14, so four partial products do.
    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [3:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         final_i,
    output logic [127:0] st_o
);

    logic [7:0] b  [16];
    logic [7:0] ak [16];
    logic [7:0] mc [16];

    always_comb begin
        st_o = '0;
        for (int i = 0; i < 16; i++) begin
            b[i] = st_i[127-8*i -: 8];
        end
        // Row r rotates right by r: column c takes old column c-r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ak[4*c+r] = INV_SBOX[b[4*((c-r+4)%4)+r]]
                          ^ rk_i[127-8*(4*c+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = gmul(ak[4*c], 4'd14)
                      ^ gmul(ak[4*c+1], 4'd11)
                      ^ gmul(ak[4*c+2], 4'd13)
                      ^ gmul(ak[4*c+3], 4'd9);
            mc[4*c+1] = gmul(ak[4*c], 4'd9)
                      ^ gmul(ak[4*c+1], 4'd14)
                      ^ gmul(ak[4*c+2], 4'd11)
                      ^ gmul(ak[4*c+3], 4'd13);
            mc[4*c+2] = gmul(ak[4*c], 4'd13)
                      ^ gmul(ak[4*c+1], 4'd9)
                      ^ gmul(ak[4*c+2], 4'd14)
                      ^ gmul(ak[4*c+3], 4'd11);
            mc[4*c+3] = gmul(ak[4*c], 4'd11)
                      ^ gmul(ak[4*c+1], 4'd13)
                      ^ gmul(ak[4*c+2], 4'd9)
                      ^ gmul(ak[4*c+3], 4'd14);
        end
        for (int i = 0; i < 16; i++) begin
            st_o[127-8*i -: 8] = final_i ? ak[i] : mc[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, external key store.
// Define AES_DEC_CBC_EN to add CBC chaining and the iv_load/iv_in ports.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
`ifdef AES_DEC_CBC_EN
    input  logic         iv_load,
    input  logic [127:0] iv_in,
`endif
    output logic         busy
);

    if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    fsm_e         state_q;
    logic [3:0]   r_q;
    logic [127:0] st_q;
    logic [127:0] st_d;
    logic         out_valid_q;
    logic [127:0] data_out_q;
    logic [127:0] mask;
    logic         accept;
    logic         hs;
    logic         is_final;

    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign hs        = out_valid_q && out_ready;
    assign is_final  = (state_q == FINAL);
    assign busy      = (state_q != IDLE);
    assign rk_idx    = (state_q == IDLE) ? NR_L : r_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

    aes_inv_round u_round (
        .st_i    (st_q),
        .rk_i    (round_key),
        .final_i (is_final),
        .st_o    (st_d)
    );

`ifdef AES_DEC_CBC_EN
    logic [127:0] chain_q;
    logic [127:0] ct_q;

    // An IV load in the accept cycle lands before the block reaches FINAL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
            ct_q    <= '0;
        end else begin
            if (state_q == IDLE && iv_load) begin
                chain_q <= iv_in;
            end else if (hs) begin
                chain_q <= ct_q;
            end
            if (accept) begin
                ct_q <= data_in;
            end
        end
    end

    assign mask = chain_q;
`else
    assign mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        st_q    <= data_in ^ round_key;
                        r_q     <= NR_M1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    st_q <= st_d;
                    r_q  <= r_q - 4'd1;
                    if (r_q == 4'd1) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    st_q        <= st_d;
                    data_out_q  <= st_d ^ mask;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
